// File: rtl/fft_sink_feeder_pkg.sv
// rtl/fft_sink_feeder_pkg.sv - shared states, defaults and constants for the FFT sink feeder
package fft_sink_feeder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_SEND = 2'd2
  } state_t;

  localparam int DEF_FFT_N  = 256;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_AD_W   = 8;

  // Offset-binary mid-scale code for an ADC of the given width
  function automatic int ad_offset(input int ad_w);
    return 1 << (ad_w - 1);
  endfunction

endpackage

// File: rtl/fft_sink_feeder_if.sv
// rtl/fft_sink_feeder_if.sv - FFT core sink (ST input) streaming port
interface fft_sink_feeder_if
  import fft_sink_feeder_pkg::*;
#(
  parameter int AD_W = DEF_AD_W
);
  logic            sink_valid;
  logic            sink_ready;
  logic            sink_sop;
  logic            sink_eop;
  logic [AD_W:0]   sink_real;
  logic [AD_W:0]   sink_imag;
  logic [1:0]      sink_error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    output sink_ready
  );
endinterface

// File: rtl/fft_frame_ram.sv
// rtl/fft_frame_ram.sv - simple dual-port frame buffer with registered, enabled read
module fft_frame_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // rdata holds while re is low, so the read port doubles as the skid stage
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_sink_feeder.sv
// rtl/fft_sink_feeder.sv - captures one ADC frame into RAM and streams it to the FFT sink
module fft_sink_feeder
  import fft_sink_feeder_pkg::*;
#(
  parameter int FFT_N  = DEF_FFT_N,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int AD_W   = DEF_AD_W,
  parameter bit CONT   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [AD_W-1:0]   ad_data,
  input  logic              ad_valid,
  fft_sink_feeder_if.master sink,
  output logic              busy,
  output logic              frame_done
);
  localparam int                DW        = AD_W + 1;
  localparam logic [DW-1:0]     AD_OFFSET = DW'(ad_offset(AD_W));
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FFT_N - 1);
  localparam logic [ADDR_W:0]   RD_END    = (ADDR_W + 1)'(FFT_N);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] xfer_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic              rd_v;
  logic              out_valid;
  logic [DW-1:0]     out_real;
  logic [DW-1:0]     ram_q;
  logic [DW-1:0]     wr_data;
  logic              wr_en, rd_en, advance, xfer, eop_xfer;

  assign wr_en    = (state == S_FILL) && ad_valid;
  assign wr_data  = {1'b0, ad_data} - AD_OFFSET;
  assign advance  = !out_valid || sink.sink_ready;
  // Read ahead whenever the RAM output slot is empty or about to drain
  assign rd_en    = (state == S_SEND) && (rd_cnt != RD_END) && (!rd_v || advance);
  assign xfer     = out_valid && sink.sink_ready;
  assign eop_xfer = xfer && (xfer_cnt == LAST_IDX);

  fft_frame_ram #(
    .DEPTH  (FFT_N),
    .ADDR_W (ADDR_W),
    .DATA_W (DW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_cnt),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_cnt[ADDR_W-1:0]),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (CONT || start) state_nx = S_FILL;
      S_FILL: if (wr_en && (wr_cnt == LAST_IDX)) state_nx = S_SEND;
      S_SEND: if (eop_xfer) state_nx = CONT ? S_FILL : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      xfer_cnt   <= '0;
      rd_v       <= 1'b0;
      out_valid  <= 1'b0;
      out_real   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= eop_xfer;
      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (rd_en) rd_cnt <= rd_cnt + 1'b1;
      else if (eop_xfer) rd_cnt <= '0;
      if (rd_en) rd_v <= 1'b1;
      else if (advance) rd_v <= 1'b0;
      if (advance) begin
        out_valid <= rd_v;
        if (rd_v) out_real <= ram_q;
      end
      if (xfer) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  assign sink.sink_valid = out_valid;
  assign sink.sink_sop   = out_valid && (xfer_cnt == '0);
  assign sink.sink_eop   = out_valid && (xfer_cnt == LAST_IDX);
  assign sink.sink_real  = out_real;
  assign sink.sink_imag  = '0;
  assign sink.sink_error = 2'b00;
  assign busy            = (state != S_IDLE);
endmodule
